component_sequencer: RTL and testbench
======================================

Name: component_sequencer

Overview:
- Parametrised successor to the Zamarine component status register.
- Turns on and off up to NUM_COMPONENTS components through a valid/ready command port.
- Commands run one at a time. Each activation or deactivation completes only after a programmable settle delay, which limits inrush from simultaneous switching.
- Sits between the control/command decoder and the component enable fabric. status drives the enables directly.

Parameters:
- NUM_COMPONENTS, 8: number of managed components; legal range 1..256.
- ID_W, (NUM_COMPONENTS>1 ? $clog2(NUM_COMPONENTS) : 1): width of cmd_id.
- START_CYCLES, 4: clock cycles from accepting an activate until status bit rises; must be >= 1.
- STOP_CYCLES, 2: clock cycles from accepting a deactivate until status bit falls; must be >= 1.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command this cycle.
- cmd_id  in  ID_W  target component; ignored for OP_ALL_OFF.
- cmd_op  in  2  opcode: 00 OP_OFF, 01 OP_ON, 10 OP_TOGGLE, 11 OP_ALL_OFF.
- status  out  NUM_COMPONENTS  settled on/off state of each component.
- busy  out  1  a transition is in progress.
- busy_id  out  ID_W  component in transition; 0 when idle or during ALL_OFF.
- done  out  1  one-cycle pulse when a command completes, including no-ops.
- err  out  1  one-cycle pulse when a command is rejected because of an out-of-range id.

Behaviour:
- Reset, sampled at a clk edge with reset=1: status=0, FSM=IDLE, counter=0, busy=0, busy_id=0, done=0, err=0, cmd_ready=0 in that cycle.
  - Reset mid-transition discards the pending command. No partial update of status occurs.
  - Reset has priority over every other event.
- cmd_ready = (state==IDLE) && !reset. It is combinational from state. A command is accepted on the edge where cmd_valid && cmd_ready.
- FSM states: IDLE, STARTING, STOPPING, ALL_STOP.
- Accept in IDLE, with k = edge of acceptance:
  - id check: OP_OFF, OP_ON or OP_TOGGLE with cmd_id >= NUM_COMPONENTS gives err=1 in cycle k+1, done=0, stays in IDLE, status unchanged. OP_ALL_OFF never errors.
  - TOGGLE resolves at edge k against status[cmd_id]: 0 means ON, 1 means OFF.
  - ON with status[id]=1, OFF with status[id]=0, or ALL_OFF with status==0 is a no-op: done=1 in cycle k+1, stays in IDLE.
  - ON with status[id]=0: go to STARTING, counter=START_CYCLES-1, latch id.
  - OFF with status[id]=1: go to STOPPING, counter=STOP_CYCLES-1, latch id.
  - ALL_OFF with status!=0: go to ALL_STOP, counter=STOP_CYCLES-1.
- STARTING, STOPPING and ALL_STOP:
  - busy=1 throughout; busy_id = latched id (0 in ALL_STOP).
  - counter decrements each edge while nonzero. On the edge where counter==0:
    - STARTING sets status[id].
    - STOPPING clears status[id].
    - ALL_STOP clears all bits.
    - done pulses, FSM returns to IDLE.
  - Net timing: status changes at edge k+START_CYCLES (or k+STOP_CYCLES). done is high in the following cycle and cmd_ready rises in that same cycle.
  - Only the latched bit of status changes; all other bits hold.
- cmd_valid while not ready: the command is neither accepted nor lost. The upstream holds it under the valid/ready rule.
- done and err are never high in the same cycle. Each lasts exactly one cycle.
- Counter width: $clog2(max(START_CYCLES,STOP_CYCLES)+1). No wrap-around is possible.

Test Plan:
- Defaults. Reset, then ON id=3 accepted at edge 10 -> busy=1, busy_id=3 in cycles 11-14; status=8'h08 after edge 14; done=1 in cycle 15; cmd_ready=0 in cycles 11-14.
- With status=8'h08: OFF id=3 at edge 20 -> status=8'h00 after edge 22; done in cycle 23. Then OFF id=3 again -> done the next cycle, no busy.
- NUM_COMPONENTS=6: ON id=6 and ON id=7 -> err pulses for 1 cycle each; status unchanged; done=0; cmd_ready stays 1.
- Status=8'hA5, ALL_OFF -> busy 2 cycles, busy_id=0, status=8'h00 afterwards. TOGGLE id=0 on status=0 -> status=8'h01 after 4 cycles; a second TOGGLE id=0 -> 8'h00 after 2 cycles.
- Back-to-back: cmd_valid held with ON id=1 then ON id=2 -> the second command is accepted only in the done cycle of the first; status=8'h06 after 8 accepted-cycle edges; no command lost.
- Reset asserted 2 cycles into STARTING id=5 -> next cycle status=0, busy=0, done=0. A subsequent ON id=5 completes with full START_CYCLES latency.

Source files
------------

// File: rtl/component_sequencer_if.sv
// rtl/component_sequencer_if.sv - command/status bundle of the component sequencer
//
// Purpose: groups the valid/ready command port and the status/progress
//          outputs of component_sequencer.
// Signals:
//   cmd_valid  command present (from decoder)
//   cmd_ready  sequencer can accept a command this cycle
//   cmd_id     target component (ignored for ALL_OFF)
//   cmd_op     00 OFF, 01 ON, 10 TOGGLE, 11 ALL_OFF
//   status     settled on/off state, drives component enables
//   busy       transition in progress
//   busy_id    component in transition, 0 when idle or during ALL_OFF
//   done       one-cycle completion pulse (no-ops included)
//   err        one-cycle pulse for an out-of-range id
// Modports: master = command source, slave = sequencer.
interface component_sequencer_if #(
   parameter int NUM_COMPONENTS = 8,
   parameter int ID_W = (NUM_COMPONENTS > 1) ? $clog2(NUM_COMPONENTS) : 1
);
   logic                      cmd_valid;
   logic                      cmd_ready;
   logic [ID_W-1:0]           cmd_id;
   logic [1:0]                cmd_op;
   logic [NUM_COMPONENTS-1:0] status;
   logic                      busy;
   logic [ID_W-1:0]           busy_id;
   logic                      done;
   logic                      err;

   modport master (
      output cmd_valid, cmd_id, cmd_op,
      input  cmd_ready, status, busy, busy_id, done, err
   );

   modport slave (
      input  cmd_valid, cmd_id, cmd_op,
      output cmd_ready, status, busy, busy_id, done, err
   );
endinterface

// File: rtl/component_sequencer.sv
// rtl/component_sequencer.sv - one-at-a-time component power sequencer with settle delays
//
// Purpose: switches up to NUM_COMPONENTS enables on/off one command at a time;
//          each change lands only after START_CYCLES / STOP_CYCLES of settle time.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    component_sequencer_if.slave (command in, status/progress out)
module component_sequencer #(
   parameter int NUM_COMPONENTS = 8,
   parameter int ID_W           = (NUM_COMPONENTS > 1) ? $clog2(NUM_COMPONENTS) : 1,
   parameter int START_CYCLES   = 4,
   parameter int STOP_CYCLES    = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   component_sequencer_if.slave   bus
);
   localparam int MAX_CYCLES = (START_CYCLES > STOP_CYCLES) ? START_CYCLES : STOP_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
   // Index space of an ID_W-bit id; status is padded to it so any id can be
   // used as an index without out-of-range selects.
   localparam int EXT_W      = 2 ** ID_W;
   localparam logic [ID_W:0]  ID_LIMIT    = (ID_W + 1)'(NUM_COMPONENTS);
   localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(START_CYCLES - 1);
   localparam logic [CNT_W-1:0] STOP_LOAD  = CNT_W'(STOP_CYCLES - 1);

   localparam logic [1:0] OP_OFF     = 2'b00;
   localparam logic [1:0] OP_ON      = 2'b01;
   localparam logic [1:0] OP_TOGGLE  = 2'b10;
   localparam logic [1:0] OP_ALL_OFF = 2'b11;

   typedef enum logic [1:0] {IDLE, STARTING, STOPPING, ALL_STOP} state_t;

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [ID_W-1:0]           id_q, id_d;
   logic [NUM_COMPONENTS-1:0] status_q, status_d;
   logic                      done_q, done_d;
   logic                      err_q, err_d;

   logic [EXT_W-1:0]          status_ext;
   logic [EXT_W-1:0]          id_mask;
   logic                      cur_on;
   logic                      want_on;
   logic                      id_bad;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         id_q     <= '0;
         status_q <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         id_q     <= id_d;
         status_q <= status_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      id_d       = id_q;
      status_d   = status_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      status_ext = '0;
      status_ext[NUM_COMPONENTS-1:0] = status_q;
      id_mask    = EXT_W'(1) << id_q;
      cur_on     = status_ext[bus.cmd_id];
      id_bad     = {1'b0, bus.cmd_id} >= ID_LIMIT;
      // TOGGLE resolves against the bit as it stands at the accept edge.
      want_on    = (bus.cmd_op == OP_ON) || ((bus.cmd_op == OP_TOGGLE) && !cur_on);

      case (state_q)
         IDLE: begin
            if (bus.cmd_valid) begin
               if (bus.cmd_op == OP_ALL_OFF) begin
                  if (status_q == '0) begin
                     done_d = 1'b1;
                  end else begin
                     state_d = ALL_STOP;
                     cnt_d   = STOP_LOAD;
                     id_d    = '0;
                  end
               end else if (id_bad) begin
                  err_d = 1'b1;
               end else if (want_on == cur_on) begin
                  done_d = 1'b1;
               end else begin
                  state_d = want_on ? STARTING : STOPPING;
                  cnt_d   = want_on ? START_LOAD : STOP_LOAD;
                  id_d    = bus.cmd_id;
               end
            end
         end
         default: begin
            if (cnt_q == '0) begin
               case (state_q)
                  STARTING: status_d = status_q | id_mask[NUM_COMPONENTS-1:0];
                  STOPPING: status_d = status_q & ~id_mask[NUM_COMPONENTS-1:0];
                  default:  status_d = '0;
               endcase
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
      endcase
   end

   assign bus.cmd_ready = (state_q == IDLE) && !reset;
   assign bus.status    = status_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.busy_id   = ((state_q == STARTING) || (state_q == STOPPING)) ? id_q : '0;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_component_sequencer.sv
// tb/tb_component_sequencer.sv - directed bench for component_sequencer (8- and 6-component instances)
module tb_component_sequencer;
   localparam logic [1:0] OFF = 2'b00, ON = 2'b01, TOG = 2'b10, ALL = 2'b11;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sel = 1'b0;
   logic       v = 1'b0;
   logic [1:0] op = 2'b00;
   logic [2:0] id = 3'd0;
   int         n_pass = 0;
   int         n_total = 0;

   always #5 clk = ~clk;

   component_sequencer_if #(.NUM_COMPONENTS(8)) ifa ();
   component_sequencer_if #(.NUM_COMPONENTS(6)) ifb ();

   assign ifa.cmd_valid = v & ~sel;
   assign ifa.cmd_op    = op;
   assign ifa.cmd_id    = id;
   assign ifb.cmd_valid = v & sel;
   assign ifb.cmd_op    = op;
   assign ifb.cmd_id    = id;

   component_sequencer #(.NUM_COMPONENTS(8)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
   component_sequencer #(.NUM_COMPONENTS(6)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

   wire       ready_m   = sel ? ifb.cmd_ready : ifa.cmd_ready;
   wire       done_m    = sel ? ifb.done      : ifa.done;
   wire       err_m     = sel ? ifb.err       : ifa.err;
   wire       busy_m    = sel ? ifb.busy      : ifa.busy;
   wire [2:0] busy_id_m = sel ? ifb.busy_id   : ifa.busy_id;
   wire [7:0] status_m  = sel ? {2'b00, ifb.status} : ifa.status;

   typedef struct {
      logic       sel;
      logic [1:0] op;
      logic [2:0] id;
      logic       err;
      int         lat;
      int         nbusy;
      logic [2:0] bid;
      logic [7:0] st;
   } vec_t;

   vec_t tv[16];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (!ready_m && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) chk({name, " ready timeout"}, 32'd0, 32'd1);
   endtask

   task automatic run_cmd(input vec_t t, input string name);
      int lat;
      int nbusy;
      logic [2:0] bid;
      sel = t.sel; op = t.op; id = t.id; v = 1'b1;
      wait_ready(name);
      tick();
      v = 1'b0;
      lat = 1; nbusy = 0; bid = 3'd0;
      while (!done_m && !err_m && lat < 20) begin
         if (busy_m) begin
            nbusy++;
            bid = busy_id_m;
         end
         tick();
         lat++;
      end
      chk({name, " latency"}, lat, t.lat);
      chk({name, " busy cycles"}, nbusy, t.nbusy);
      chk({name, " busy_id"}, {29'd0, bid}, {29'd0, t.bid});
      chk({name, " err"}, {31'd0, err_m}, {31'd0, t.err});
      chk({name, " done"}, {31'd0, done_m}, {31'd0, ~t.err});
      chk({name, " status"}, {24'd0, status_m}, {24'd0, t.st});
      if (t.err) chk({name, " ready on err"}, {31'd0, ready_m}, 32'd1);
      tick();
      chk({name, " pulse one cycle"}, {30'd0, done_m, err_m}, 32'd0);
   endtask

   initial begin
      int nr;
      int nd;
      int lat;
      //          sel  op   id  err lat busy bid  status
      tv[0]  = '{1'b0, ON,  3'd3, 1'b0, 5, 4, 3'd3, 8'h08};
      tv[1]  = '{1'b0, OFF, 3'd3, 1'b0, 3, 2, 3'd3, 8'h00};
      tv[2]  = '{1'b0, OFF, 3'd3, 1'b0, 1, 0, 3'd0, 8'h00};
      tv[3]  = '{1'b0, ON,  3'd0, 1'b0, 5, 4, 3'd0, 8'h01};
      tv[4]  = '{1'b0, ON,  3'd2, 1'b0, 5, 4, 3'd2, 8'h05};
      tv[5]  = '{1'b0, ON,  3'd5, 1'b0, 5, 4, 3'd5, 8'h25};
      tv[6]  = '{1'b0, TOG, 3'd7, 1'b0, 5, 4, 3'd7, 8'hA5};
      tv[7]  = '{1'b0, ON,  3'd5, 1'b0, 1, 0, 3'd0, 8'hA5};
      tv[8]  = '{1'b0, ALL, 3'd6, 1'b0, 3, 2, 3'd0, 8'h00};
      tv[9]  = '{1'b0, ALL, 3'd1, 1'b0, 1, 0, 3'd0, 8'h00};
      tv[10] = '{1'b0, TOG, 3'd0, 1'b0, 5, 4, 3'd0, 8'h01};
      tv[11] = '{1'b0, TOG, 3'd0, 1'b0, 3, 2, 3'd0, 8'h00};
      tv[12] = '{1'b1, ON,  3'd6, 1'b1, 1, 0, 3'd0, 8'h00};
      tv[13] = '{1'b1, ON,  3'd7, 1'b1, 1, 0, 3'd0, 8'h00};
      tv[14] = '{1'b1, ON,  3'd5, 1'b0, 5, 4, 3'd5, 8'h20};
      tv[15] = '{1'b1, TOG, 3'd6, 1'b1, 1, 0, 3'd0, 8'h20};

      // Reset state, sampled while reset is still asserted.
      tick();
      tick();
      chk("reset status a", {24'd0, ifa.status}, 32'd0);
      chk("reset status b", {26'd0, ifb.status}, 32'd0);
      chk("reset busy", {31'd0, ifa.busy}, 32'd0);
      chk("reset busy_id", {29'd0, ifa.busy_id}, 32'd0);
      chk("reset done/err", {30'd0, ifa.done, ifa.err}, 32'd0);
      chk("reset ready low", {31'd0, ifa.cmd_ready}, 32'd0);
      reset = 1'b0;
      #1;
      chk("ready after reset", {31'd0, ifa.cmd_ready}, 32'd1);

      for (int i = 0; i < 16; i++) run_cmd(tv[i], $sformatf("vec%0d", i));

      // Back-to-back: ON 1 then ON 2 with valid held throughout.
      sel = 1'b0; op = ON; id = 3'd1; v = 1'b1;
      wait_ready("b2b first");
      tick();
      id = 3'd2;
      nr = 0;
      for (int i = 0; i < 4; i++) begin
         if (ready_m) nr++;
         tick();
      end
      chk("b2b ready low while busy", nr, 0);
      chk("b2b done of first", {31'd0, done_m}, 32'd1);
      chk("b2b ready in done cycle", {31'd0, ready_m}, 32'd1);
      chk("b2b status after first", {24'd0, status_m}, 32'h02);
      tick();
      v = 1'b0;
      chk("b2b second accepted", {31'd0, busy_m}, 32'd1);
      lat = 1;
      while (!done_m && lat < 20) begin
         tick();
         lat++;
      end
      chk("b2b second latency", lat, 5);
      chk("b2b status after second", {24'd0, status_m}, 32'h06);
      tick();

      // Reset two cycles into STARTING id=5.
      op = ON; id = 3'd5; v = 1'b1;
      wait_ready("rst seq");
      tick();
      v = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      chk("mid reset status", {24'd0, status_m}, 32'd0);
      chk("mid reset busy", {31'd0, busy_m}, 32'd0);
      chk("mid reset done", {31'd0, done_m}, 32'd0);
      chk("mid reset ready low", {31'd0, ready_m}, 32'd0);
      reset = 1'b0;
      nd = 0;
      for (int i = 0; i < 5; i++) begin
         if (done_m || busy_m) nd++;
         tick();
      end
      chk("discarded command silent", nd, 0);
      run_cmd('{1'b0, ON, 3'd5, 1'b0, 5, 4, 3'd5, 8'h20}, "on5 after reset");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
